// File: rtl/fp_accumulator.sv
// rtl/fp_accumulator.sv - binary32 running-sum accumulator, four cycles per operand, groups ended by in_last.
// Define FP_ACC_RNE_EN for round-to-nearest-even; the default build truncates and saturates on overflow.
module fp_accumulator #(
    parameter int          COUNT_W  = 16,
    parameter logic [31:0] INIT_SUM = 32'h00000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    input  logic               acc_clear,
    output logic [31:0]        sum,
    output logic               sum_valid,
    output logic [COUNT_W-1:0] count,
    output logic               overflow
);

`ifdef FP_ACC_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM} state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic [31:0]        r_sum;
    logic               r_sum_valid;
    logic [COUNT_W-1:0] r_count;
    logic               r_overflow;
    logic [31:0]        r_op;
    logic               r_last;
    logic               r_spec;
    logic [31:0]        r_spec_val;
    logic               r_a_sign;
    logic               r_b_sign;
    logic [7:0]         r_exp;
    logic [23:0]        r_a_mant;
    logic [26:0]        r_b_mant;
    logic [27:0]        r_mag;
    logic               r_res_sign;

    // Special-value detection on the raw encodings
    logic        w_s_nan, w_s_inf, w_o_nan, w_o_inf, w_spec;
    logic [31:0] w_spec_val;
    always_comb begin
        w_s_nan    = (r_sum[30:23] == 8'hFF) && (r_sum[22:0] != 23'd0);
        w_s_inf    = (r_sum[30:23] == 8'hFF) && (r_sum[22:0] == 23'd0);
        w_o_nan    = (r_op[30:23] == 8'hFF) && (r_op[22:0] != 23'd0);
        w_o_inf    = (r_op[30:23] == 8'hFF) && (r_op[22:0] == 23'd0);
        w_spec     = w_s_nan || w_s_inf || w_o_nan || w_o_inf;
        w_spec_val = r_op;
        if (w_s_nan || w_o_nan || (w_s_inf && w_o_inf && (r_sum[31] != r_op[31])))
            w_spec_val = 32'h7FC00000;
        else if (w_s_inf)
            w_spec_val = r_sum;
    end

    // Alignment: denormals flushed to zero, larger magnitude becomes A
    logic [30:0] w_s_mag, w_o_mag;
    logic [31:0] w_big, w_small;
    logic [23:0] w_big_mant, w_small_mant;
    logic [7:0]  w_diff;
    logic [26:0] w_b_ext, w_b_shr, w_b_aligned;
    logic        w_b_lost;
    always_comb begin
        w_s_mag      = (r_sum[30:23] == 8'd0) ? 31'd0 : r_sum[30:0];
        w_o_mag      = (r_op[30:23] == 8'd0) ? 31'd0 : r_op[30:0];
        if (w_o_mag > w_s_mag) begin
            w_big   = {r_op[31], w_o_mag};
            w_small = {r_sum[31], w_s_mag};
        end else begin
            w_big   = {r_sum[31], w_s_mag};
            w_small = {r_op[31], w_o_mag};
        end
        w_big_mant   = {|w_big[30:23], w_big[22:0]};
        w_small_mant = {|w_small[30:23], w_small[22:0]};
        w_diff       = w_big[30:23] - w_small[30:23];
        w_b_ext      = {w_small_mant, 3'b000};
        w_b_shr      = w_b_ext >> w_diff;
        w_b_lost     = |(w_b_ext & ~({27{1'b1}} << w_diff));
        if (w_diff >= 8'd27)
            w_b_aligned = {26'd0, |w_small_mant};
        else
            w_b_aligned = {w_b_shr[26:1], w_b_shr[0] | w_b_lost};
    end

    logic [27:0] w_add_mag;
    always_comb begin
        if (r_a_sign == r_b_sign)
            w_add_mag = {1'b0, r_a_mant, 3'b000} + {1'b0, r_b_mant};
        else
            w_add_mag = {1'b0, r_a_mant, 3'b000} - {1'b0, r_b_mant};
    end

    logic [4:0] w_lzc;
    always_comb begin
        w_lzc = 5'd0;
        for (int i = 0; i < 27; i++)
            if (r_mag[i]) w_lzc = 5'(26 - i);
    end

    // Normalise, round, then range-check the final exponent
    logic [26:0]       w_norm_m;
    logic signed [9:0] w_norm_e, w_fin_e;
    logic              w_inc;
    logic [24:0]       w_rnd;
    logic [23:0]       w_fin_m;
    logic              w_ovf;
    logic [31:0]       w_result;
    always_comb begin
        if (r_mag[27]) begin
            w_norm_m = {r_mag[27:2], r_mag[1] | r_mag[0]};
            w_norm_e = $signed({2'b00, r_exp}) + 10'sd1;
        end else begin
            w_norm_m = r_mag[26:0] << w_lzc;
            w_norm_e = $signed({2'b00, r_exp}) - $signed({5'd0, w_lzc});
        end
        w_inc = RNE_EN & w_norm_m[2] & (w_norm_m[1] | w_norm_m[0] | w_norm_m[3]);
        w_rnd = {1'b0, w_norm_m[26:3]} + {24'd0, w_inc};
        if (w_rnd[24]) begin
            w_fin_m = w_rnd[24:1];
            w_fin_e = w_norm_e + 10'sd1;
        end else begin
            w_fin_m = w_rnd[23:0];
            w_fin_e = w_norm_e;
        end
        w_ovf    = 1'b0;
        w_result = {r_res_sign, w_fin_e[7:0], w_fin_m[22:0]};
        if (r_spec) begin
            w_result = r_spec_val;
        end else if ((r_mag == 28'd0) || (w_fin_e < 10'sd1)) begin
            w_result = 32'h00000000;
        end else if (w_fin_e >= 10'sd255) begin
            w_ovf    = 1'b1;
            w_result = RNE_EN ? {r_res_sign, 8'hFF, 23'd0} : {r_res_sign, 31'h7F7FFFFF};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_sum       <= INIT_SUM;
            r_sum_valid <= 1'b0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_op        <= 32'd0;
            r_last      <= 1'b0;
            r_spec      <= 1'b0;
            r_spec_val  <= 32'd0;
            r_a_sign    <= 1'b0;
            r_b_sign    <= 1'b0;
            r_exp       <= 8'd0;
            r_a_mant    <= 24'd0;
            r_b_mant    <= 27'd0;
            r_mag       <= 28'd0;
            r_res_sign  <= 1'b0;
        end else if (acc_clear) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_sum       <= INIT_SUM;
            r_sum_valid <= 1'b0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
        end else if (r_sum_valid) begin
            // Edge after the group pulse: restart the group and reopen the input
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_sum       <= INIT_SUM;
            r_sum_valid <= 1'b0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_op       <= in_data;
                        r_last     <= in_last;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_spec     <= w_spec;
                    r_spec_val <= w_spec_val;
                    r_a_sign   <= w_big[31];
                    r_b_sign   <= w_small[31];
                    r_exp      <= w_big[30:23];
                    r_a_mant   <= w_big_mant;
                    r_b_mant   <= w_b_aligned;
                    r_state    <= S_ADD;
                end
                S_ADD: begin
                    r_mag      <= w_add_mag;
                    r_res_sign <= r_a_sign;
                    r_state    <= S_NORM;
                end
                default: begin
                    r_sum   <= w_result;
                    r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
                    if (w_ovf) r_overflow <= 1'b1;
                    if (r_last) r_sum_valid <= 1'b1;
                    else        r_in_ready  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign sum       = r_sum;
    assign sum_valid = r_sum_valid;
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule
